// File: rtl/uart_tx.sv
// uart_tx: buffered 8-bit UART transmitter (8N1, or 8E1 when UART_TX_PARITY_EN
// is defined). Bytes enter a small FIFO and are serialised LSB first.
//
// Parameters: CLK_FREQ (Hz), BAUD (bit/s), FIFO_DEPTH (power of two, >= 2)
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous active-low reset
//   tx_data   byte offered for transmission
//   tx_valid  tx_data is valid
//   tx_ready  FIFO can accept a byte this cycle (registered !full)
//   tx        serial line, idle high, registered
//   busy      frame in progress or FIFO non-empty
// Macro: UART_TX_PARITY_EN adds an even-parity bit between data and stop.
module uart_tx #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy
);

  localparam int unsigned DIV = CLK_FREQ / BAUD;
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned NW  = AW + 1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t          state, state_nxt;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [NW-1:0]   count, count_nxt;
  logic [CW-1:0]   bit_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            push, pop, tick, tx_c;
`ifdef UART_TX_PARITY_EN
  logic            par;
`endif

  assign push = tx_valid && tx_ready;
  assign tick = (bit_cnt == CW'(DIV - 1));

  // Occupancy after this edge; a push and pop together leave it unchanged.
  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + NW'(1);
      2'b01:   count_nxt = count - NW'(1);
      default: count_nxt = count;
    endcase
  end

  // Next-state, FIFO pop and line level for the current state.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    tx_c      = 1'b1;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop       = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        tx_c = 1'b0;
        if (tick) state_nxt = DATA;
      end
      DATA: begin
        tx_c = shreg[0];
        if (tick && bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx_c = par;
        if (tick) state_nxt = STOP;
      end
`endif
      STOP: begin
        tx_c = 1'b1;
        if (tick) begin
          if (count != '0) begin
            pop       = 1'b1;
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  // Pointers, counters, shift register and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      bit_cnt  <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
`ifdef UART_TX_PARITY_EN
      par      <= 1'b0;
`endif
      tx       <= 1'b1;
      tx_ready <= 1'b0;
      busy     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      count <= count_nxt;

      if (state == IDLE || tick) bit_cnt <= '0;
      else                       bit_cnt <= bit_cnt + CW'(1);

      if (pop) begin
        shreg   <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + AW'(1);
        bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
        par     <= ^mem[rd_ptr];
`endif
      end else if (state == DATA && tick) begin
        shreg   <= shreg >> 1;
        bit_idx <= bit_idx + 3'd1;
      end

      // tx lags the state by one edge, so every level still lasts DIV cycles.
      tx       <= tx_c;
      tx_ready <= (count_nxt != NW'(FIFO_DEPTH));
      busy     <= (state_nxt != IDLE) || (count_nxt != '0);
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx with a small divider (DIV = 11).
// A scoreboard queue holds accepted bytes; a line monitor decodes tx and
// compares every sampled bit level against the expected frame.
module tb_uart_tx;
  localparam int unsigned CLK_FREQ = 100;
  localparam int unsigned BAUD     = 9;
  localparam int unsigned DIV      = 11;
  localparam int unsigned DEPTH    = 4;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned NB = 11;
`else
  localparam int unsigned NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx, busy;

  uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx(tx), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       par;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   frames = 0;
  int   last_fall = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Line monitor: samples on the falling edge, away from the active edge.
  logic [11:0] fb;
  exp_t        cur;
  int          samp, bad;
  bit          active = 1'b0;
  bit          pend = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      active = 1'b0;
      pend   = 1'b0;
      sb.delete();
    end else begin
      if (!active) begin
        if (pend) begin
          check("no_gap", 32'(tx), 32'd0);
          pend = 1'b0;
        end
        if (tx == 1'b0) begin
          check("start_expected", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            cur = sb.pop_front();
            fb = '1;
            fb[0] = 1'b0;
            fb[8:1] = cur.d;
`ifdef UART_TX_PARITY_EN
            fb[9] = cur.par;
`endif
            samp = 0;
            bad = 0;
            active = 1'b1;
            last_fall = cyc;
          end
        end
      end
      if (active) begin
        if (tx !== fb[samp / DIV]) bad++;
        samp++;
        if (samp == int'(NB * DIV)) begin
          check($sformatf("frame_%02h", cur.d), 32'(bad), 32'd0);
          active = 1'b0;
          frames++;
          pend = (sb.size() != 0);
        end
      end
    end
  end

  // Drive one byte for one cycle (called at a falling edge); valid stays high.
  task automatic push(input logic [7:0] d, input logic p, output int acc_edge, output logic acc);
    tx_data  = d;
    tx_valid = 1'b1;
    acc      = tx_ready;
    acc_edge = cyc + 1;
    @(posedge clk);
    if (acc) sb.push_back('{d, p});
    @(negedge clk);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("idle_timeout", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  exp_t vecs[8];
  exp_t burst[5];

  initial begin
    int   e, f0, lows;
    logic a;

    // Parity constants: even parity over the data byte.
    vecs[0] = '{8'h55, 1'b0};
    vecs[1] = '{8'h00, 1'b0};
    vecs[2] = '{8'h07, 1'b1};
    vecs[3] = '{8'h03, 1'b0};
    vecs[4] = '{8'hFF, 1'b0};
    vecs[5] = '{8'h80, 1'b1};
    vecs[6] = '{8'hA5, 1'b0};
    vecs[7] = '{8'h01, 1'b1};
    burst[0] = '{8'h11, 1'b0};
    burst[1] = '{8'h22, 1'b0};
    burst[2] = '{8'h33, 1'b0};
    burst[3] = '{8'h44, 1'b0};
    burst[4] = '{8'h55, 1'b0};

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_ready", 32'(tx_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_rst", 32'(tx_ready), 32'd1);
    @(negedge clk);

    // Single frames from idle: content, parity, latency, return to idle.
    for (int i = 0; i < 8; i++) begin
      f0 = frames;
      push(vecs[i].d, vecs[i].par, e, a);
      tx_valid = 1'b0;
      check($sformatf("accept_%02h", vecs[i].d), 32'(a), 32'd1);
      wait_idle(int'(NB * DIV) + 20);
      check($sformatf("frames_%02h", vecs[i].d), 32'(frames - f0), 32'd1);
      check($sformatf("latency_%02h", vecs[i].d), 32'(last_fall - e), 32'd2);
      check($sformatf("idle_tx_%02h", vecs[i].d), 32'(tx), 32'd1);
    end

    // Burst of five: one pops at once, four fill the FIFO, sixth is refused.
    f0 = frames;
    for (int k = 0; k < 5; k++) begin
      push(burst[k].d, burst[k].par, e, a);
      check($sformatf("burst_acc%0d", k), 32'(a), 32'd1);
    end
    push(8'h66, 1'b0, e, a);
    tx_valid = 1'b0;
    check("burst_full_ready", 32'(a), 32'd0);
    wait_idle(6 * int'(NB * DIV));
    check("burst_frames", 32'(frames - f0), 32'd5);

    // Reset during the data bits of 0xA5 with two bytes queued.
    push(8'hA5, 1'b0, e, a);
    push(8'h3C, 1'b0, e, a);
    push(8'hC3, 1'b0, e, a);
    tx_valid = 1'b0;
    repeat (2 + 4 * DIV) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_tx", 32'(tx), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ready", 32'(tx_ready), 32'd0);
    f0 = frames;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_ready_after", 32'(tx_ready), 32'd1);
    lows = 0;
    repeat (3 * NB * DIV) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("post_rst_quiet", 32'(lows), 32'd0);
    check("post_rst_frames", 32'(frames - f0), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000, SHALL be the clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, SHALL be the line rate in bit/s.
REQ-003 Parameter FIFO_DEPTH, default 4 (power of two, >=2), SHALL be the number of buffered bytes.
REQ-004 clk  input  1  SHALL be the single system clock; all logic is on its rising edge.
REQ-005 reset  input  1  SHALL be the asynchronous, active-low reset (0 = in reset).
REQ-006 tx_data  input  8  SHALL be the byte offered for transmission.
REQ-007 tx_valid  input  1  SHALL mean that tx_data holds a byte to send.
REQ-008 tx_ready  output  1  SHALL mean that the FIFO can accept a byte this cycle.
REQ-009 tx  output  1  SHALL be the serial line, idle high, driven from a flop.
REQ-010 busy  output  1  SHALL be high while a frame is in progress or the FIFO is non-empty.

Function
REQ-011 DIV SHALL equal CLK_FREQ/BAUD using integer division (10416 at default), and every line bit SHALL last exactly DIV clk cycles.
REQ-012 A byte SHALL be accepted on a rising edge where tx_valid=1 and tx_ready=1; tx_data is otherwise ignored.
REQ-013 tx_ready SHALL equal !full, with no dependence on a same-cycle pop; a push while full SHALL be rejected.
REQ-014 The FIFO SHALL be FIFO_DEPTH entries, in-order, with wrap-around read and write pointers and an occupancy count of log2(FIFO_DEPTH)+1 bits.
REQ-015 The FSM states SHALL be IDLE, START, DATA, PARITY (only when compiled in), and STOP.
REQ-016 In IDLE, tx=1; if the FIFO is non-empty, the FSM SHALL pop the head into a shift register and enter START on the same edge.
REQ-017 In START, tx=0 for DIV cycles, then the FSM SHALL enter DATA.
REQ-018 In DATA, eight bits SHALL be sent LSB first, DIV cycles each, then the FSM SHALL enter PARITY or STOP.
REQ-019 In STOP, tx=1 for DIV cycles; at the end, if the FIFO is non-empty, the FSM SHALL pop and enter START directly, otherwise it SHALL enter IDLE.
REQ-020 Latency: with the FSM in IDLE and the FIFO empty, a byte accepted at edge N SHALL cause tx to fall at edge N+2.
REQ-021 Back-to-back frames SHALL have no idle gap: the next start bit SHALL follow the stop bit immediately.
REQ-022 A simultaneous push and pop SHALL leave the count unchanged and lose no data.
REQ-023 The bit-time counter SHALL count 0..DIV-1 and wrap; the bit index SHALL count 0..7.

Reset
REQ-024 While reset=0, the outputs SHALL be tx=1, tx_ready=0, busy=0, the FSM SHALL be IDLE, and the FIFO pointers, count and counters SHALL be 0, all asynchronously.
REQ-025 After reset is released, tx_ready SHALL be 1 from the first rising edge.
REQ-026 Reset asserted mid-frame SHALL abandon the frame, drive tx=1 immediately, and discard the FIFO contents.

Configuration
REQ-027 Macro UART_TX_PARITY_EN SHALL control parity generation.
REQ-028 When UART_TX_PARITY_EN is defined, the PARITY state SHALL send the even-parity bit (XOR of the 8 data bits) for DIV cycles between DATA and STOP, giving an 11-bit frame.
REQ-029 When UART_TX_PARITY_EN is undefined, there SHALL be no PARITY state or logic, and the frame SHALL be 10 bits (8N1).

Verification
REQ-030 Push 0x55 after reset -> tx = 0,1,0,1,0,1,0,1,0,1 with each level lasting 10416 cycles, then tx=1 and busy=0.
REQ-031 Push 0x00 -> tx low for 9x10416 cycles, then high for 10416 cycles; the tx falling edge occurs exactly 2 edges after acceptance.
REQ-032 Push 0x11,0x22,0x33,0x44,0x55 on consecutive cycles -> the first 5 are accepted (one pops immediately), a 6th push sees tx_ready=0, and the bytes are sent in order with no idle gap between stop and start bits.
REQ-033 Assert reset mid-DATA of 0xA5 with 2 bytes queued -> tx=1 at once, busy=0, no further frames are sent, and tx_ready=1 after release.
REQ-034 With UART_TX_PARITY_EN, push 0x07 -> parity bit 1 and an 11-bit frame; push 0x03 -> parity bit 0.
REQ-035 Connect tx to the existing uart receiver via the loopback top and push 0x55 then 0x00 -> the receiver reports 0x55 then 0x00 with no framing error.
